// File: rtl/exp_3c_dec.sv
// 5-to-32 registered one-hot decoder built from a 2-to-4 pre-decoder
// that enables one of four 3-to-8 sub-decoders.
module exp_3c_dec #(
  parameter int SEL_W = 5,
  parameter int SUB_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W:0]    din,
  input  logic              en,
  output logic [2**SEL_W-1:0] dout,
  output logic              dout_vld,
  output logic              range_err
);

  localparam int DOUT_W = 2**SEL_W;
  localparam int PRE_W  = SEL_W - SUB_W;
  localparam int NSUB   = 2**PRE_W;
  localparam int SUB_N  = 2**SUB_W;

  logic [NSUB-1:0]   pre;
  logic [DOUT_W-1:0] dec;

  // din[SEL_W] is the out-of-range flag; it blocks every sub-decoder
  for (genvar k = 0; k < NSUB; k++) begin : g_sub
    localparam logic [PRE_W-1:0] K = PRE_W'(k);
    assign pre[k] = en & ~din[SEL_W] & (din[SEL_W-1:SUB_W] == K);
    assign dec[SUB_N*k +: SUB_N] =
      pre[k] ? (SUB_N'(1) << din[SUB_W-1:0]) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout      <= '0;
      dout_vld  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      dout      <= dec;
      dout_vld  <= |pre;
      range_err <= en & din[SEL_W];
    end
  end

endmodule

// File: tb/tb_exp_3c_dec.sv
// Bench for exp_3c_dec: vector table plus hand-written sequences,
// expected results queued at drive time and checked one edge later.
module tb_exp_3c_dec;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [5:0]  din;
    logic [31:0] dout;
    logic        vld;
    logic        rerr;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic        vld;
    logic        rerr;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  din;
  logic        en;
  logic [31:0] dout;
  logic        dout_vld;
  logic        range_err;

  int tests;
  int fails;

  vec_t tbl[$];
  exp_t sb[$];

  exp_3c_dec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .en        (en),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .range_err (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e,
                     input logic [5:0] d, input logic [31:0] o,
                     input logic v, input logic x, input string n);
    vec_t t;
    t.rst_n = r; t.en = e; t.din = d;
    t.dout = o; t.vld = v; t.rerr = x; t.name = n;
    tbl.push_back(t);
  endtask

  task automatic step(input logic r, input logic e,
                      input logic [5:0] d, input logic [31:0] o,
                      input logic v, input logic x, input string n);
    exp_t ex;
    exp_t got;
    rst_n = r;
    en    = e;
    din   = d;
    ex.dout = o; ex.vld = v; ex.rerr = x; ex.name = n;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty", n);
    end else begin
      got = sb.pop_front();
      if (dout !== got.dout || dout_vld !== got.vld ||
          range_err !== got.rerr) begin
        fails++;
        $display("FAIL %s: got dout=%h vld=%b rerr=%b want dout=%h vld=%b rerr=%b",
                 got.name, dout, dout_vld, range_err,
                 got.dout, got.vld, got.rerr);
      end
    end
    tests++;
    if (!$onehot0(dout) || (dout_vld !== (dout != 32'h0))) begin
      fails++;
      $display("FAIL %s_onehot: got dout=%h vld=%b want onehot0 and vld=(dout!=0)",
               n, dout, dout_vld);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    din   = 6'd0;

    add(1'b0, 1'b1, 6'd7, 32'h0, 1'b0, 1'b0, "reset");
    add(1'b1, 1'b1, 6'd0, 32'h0000_0001, 1'b1, 1'b0, "din0");
    add(1'b1, 1'b1, 6'd8, 32'h0000_0100, 1'b1, 1'b0, "din8");
    add(1'b1, 1'b1, 6'd31, 32'h8000_0000, 1'b1, 1'b0, "din31");
    for (int i = 0; i < 32; i++)
      add(1'b1, 1'b1, 6'(i), 32'h1 << i, 1'b1, 1'b0,
          $sformatf("sweep_en_%0d", i));
    for (int i = 0; i < 32; i++)
      add(1'b1, 1'b0, 6'(i), 32'h0, 1'b0, 1'b0,
          $sformatf("sweep_dis_%0d", i));
    add(1'b1, 1'b1, 6'b100101, 32'h0, 1'b0, 1'b1, "range");
    add(1'b1, 1'b1, 6'd5, 32'h0000_0020, 1'b1, 1'b0, "after_range");
    add(1'b1, 1'b0, 6'b111111, 32'h0, 1'b0, 1'b0, "range_dis");
    add(1'b1, 1'b1, 6'b100000, 32'h0, 1'b0, 1'b1, "range_zero");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst_n, tbl[i].en, tbl[i].din,
           tbl[i].dout, tbl[i].vld, tbl[i].rerr, tbl[i].name);

    step(1'b1, 1'b1, 6'd17, 32'h0002_0000, 1'b1, 1'b0, "mid_pre");
    step(1'b0, 1'b1, 6'd17, 32'h0, 1'b0, 1'b0, "mid_rst");
    step(1'b1, 1'b1, 6'd17, 32'h0002_0000, 1'b1, 1'b0, "mid_post");

    step(1'b1, 1'b1, 6'd3, 32'h0000_0008, 1'b1, 1'b0, "tog_on0");
    step(1'b1, 1'b0, 6'd3, 32'h0, 1'b0, 1'b0, "tog_off");
    step(1'b1, 1'b1, 6'd3, 32'h0000_0008, 1'b1, 1'b0, "tog_on1");
    step(1'b1, 1'b1, 6'b100011, 32'h0, 1'b0, 1'b1, "tog_err");
    step(1'b0, 1'b1, 6'b100011, 32'h0, 1'b0, 1'b0, "rst_err");

    for (int i = 0; i < 20; i++) begin
      logic [5:0] d;
      logic       e;
      d = 6'($urandom_range(0, 63));
      e = 1'($urandom_range(0, 1));
      if (!e)
        step(1'b1, e, d, 32'h0, 1'b0, 1'b0, $sformatf("rnd_%0d", i));
      else if (d[5])
        step(1'b1, e, d, 32'h0, 1'b0, 1'b1, $sformatf("rnd_%0d", i));
      else
        step(1'b1, e, d, 32'h1 << d[4:0], 1'b1, 1'b0,
             $sformatf("rnd_%0d", i));
    end

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
